// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_pkg
// Description : Shared state encodings, controller constants and the
//               arbitration helper for the two-port SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_WAIT_REL = 3'd4
    } arb_state_t;

    // Number of cycles the controller holds ack high per transaction.
    localparam int c_ack_width = 5;

    // Returns 1 when port 1 wins. On a tie, fixed priority favours port 0,
    // otherwise the port not granted last wins.
    function automatic logic arb_pick(input logic req0, input logic req1,
                                      input logic last, input logic prio_fixed);
        if (req0 && req1) begin
            return prio_fixed ? 1'b0 : ~last;
        end
        return req1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync2.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync2
// Description : Two-flop reset synchronizer, asynchronous assert and
//               synchronous deassert.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic r_meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            o_rst_n <= 1'b0;
        end else begin
            r_meta  <= 1'b1;
            o_rst_n <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one SDRAM controller between two masters, owns the
//               controller reset and init wait, and turns the multi-cycle
//               controller ack into a one-cycle per-port completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int PRIORITY    = 0,
    parameter int INIT_CYCLES = 32,
    parameter int TIMEOUT     = 31
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [23:0] p0_ad,
    input  logic        p0_nwr,
    input  logic [15:0] p0_din,
    output logic        p0_ack,
    output logic [15:0] p0_dout,
    input  logic        p1_req,
    input  logic [23:0] p1_ad,
    input  logic        p1_nwr,
    input  logic [15:0] p1_din,
    output logic        p1_ack,
    output logic [15:0] p1_dout,
    output logic [23:0] mem_ad,
    output logic [15:0] mem_din,
    output logic        mem_nwr,
    output logic        mem_as,
    output logic        mem_rst,
    input  logic [15:0] mem_dout,
    input  logic        mem_ack,
    output logic        err
);

    localparam int c_cnt_max = (INIT_CYCLES > TIMEOUT) ? INIT_CYCLES : TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout   = c_cnt_w'(TIMEOUT);
    localparam logic               c_prio_fix  = (PRIORITY != 0);

    arb_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_grant;
    logic               w_rst_n_sync;
    logic               w_pick;
    logic               w_req_gnt;

    rst_sync2 u_rst_sync (
        .i_clk   (clk_in),
        .i_rst_n (rst_n),
        .o_rst_n (w_rst_n_sync)
    );

    assign mem_rst = ~w_rst_n_sync;

    always_comb begin
        w_pick    = arb_pick(p0_req, p1_req, r_grant, c_prio_fix);
        w_req_gnt = r_grant ? p1_req : p0_req;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_grant <= 1'b0;
            mem_ad  <= '0;
            mem_din <= '0;
            mem_nwr <= 1'b1;
            mem_as  <= 1'b0;
            p0_ack  <= 1'b0;
            p1_ack  <= 1'b0;
            p0_dout <= '0;
            p1_dout <= '0;
            err     <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            mem_as <= 1'b0;
            case (r_state)
                // The init count only runs once the controller reset is released.
                ST_INIT: begin
                    if (w_rst_n_sync) begin
                        if (r_cnt == c_init_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_grant <= w_pick;
                        mem_ad  <= w_pick ? p1_ad  : p0_ad;
                        mem_nwr <= w_pick ? p1_nwr : p0_nwr;
                        mem_din <= w_pick ? p1_din : p0_din;
                        mem_as  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        // A port that dropped its request gets neither data nor ack.
                        if (w_req_gnt) begin
                            if (mem_nwr && r_grant) begin
                                p1_dout <= mem_dout;
                            end
                            if (mem_nwr && !r_grant) begin
                                p0_dout <= mem_dout;
                            end
                            p0_ack <= ~r_grant;
                            p1_ack <= r_grant;
                        end
                        r_state <= ST_WAIT_REL;
                    end else if (r_cnt == c_timeout) begin
                        err     <= 1'b1;
                        p0_ack  <= w_req_gnt & ~r_grant;
                        p1_ack  <= w_req_gnt & r_grant;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!mem_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter with a behavioural
//               controller model; a fixed-priority twin shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int c_init = 32;
    localparam int c_tmo  = 31;
    localparam int c_lat  = 11;

    typedef struct {
        logic        port;
        logic        nwr;
        logic [23:0] ad;
        logic [15:0] din;
        logic [15:0] exp_dout;
    } vec_t;

    typedef struct {
        logic        port;
        logic        chk_lat;
        logic [15:0] dout;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req, p0_nwr, p1_nwr;
    logic [23:0] p0_ad, p1_ad;
    logic [15:0] p0_din, p1_din;
    logic        p0_ack, p1_ack, p0_ack_b, p1_ack_b;
    logic [15:0] p0_dout, p1_dout, p0_dout_b, p1_dout_b;
    logic [23:0] mem_ad, mem_ad_b;
    logic [15:0] mem_din, mem_din_b;
    logic        mem_nwr, mem_nwr_b, mem_as, mem_as_b, mem_rst, mem_rst_b;
    logic        err, err_b;
    logic [15:0] mem_dout;
    logic        mem_ack;

    always #5 clk_in = ~clk_in;

    sdram_arbiter #(.PRIORITY(0), .INIT_CYCLES(c_init), .TIMEOUT(c_tmo)) u_dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .p0_req(p0_req), .p0_ad(p0_ad), .p0_nwr(p0_nwr), .p0_din(p0_din),
        .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_ad(p1_ad), .p1_nwr(p1_nwr), .p1_din(p1_din),
        .p1_ack(p1_ack), .p1_dout(p1_dout),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_nwr(mem_nwr), .mem_as(mem_as),
        .mem_rst(mem_rst), .mem_dout(mem_dout), .mem_ack(mem_ack), .err(err)
    );

    // Twin in lock-step with the main instance; only its grants are examined.
    sdram_arbiter #(.PRIORITY(1), .INIT_CYCLES(c_init), .TIMEOUT(c_tmo)) u_dut_prio (
        .clk_in(clk_in), .rst_n(rst_n),
        .p0_req(p0_req), .p0_ad(p0_ad), .p0_nwr(p0_nwr), .p0_din(p0_din),
        .p0_ack(p0_ack_b), .p0_dout(p0_dout_b),
        .p1_req(p1_req), .p1_ad(p1_ad), .p1_nwr(p1_nwr), .p1_din(p1_din),
        .p1_ack(p1_ack_b), .p1_dout(p1_dout_b),
        .mem_ad(mem_ad_b), .mem_din(mem_din_b), .mem_nwr(mem_nwr_b), .mem_as(mem_as_b),
        .mem_rst(mem_rst_b), .mem_dout(mem_dout), .mem_ack(mem_ack), .err(err_b)
    );

    // Behavioural controller: ack rises 12 cycles after as and stays high c_ack_width cycles.
    logic        stub_mute = 1'b0;
    logic        m_busy;
    int          m_cnt;
    logic [23:0] m_ad;
    logic        m_nwr;
    logic [15:0] m_din;
    logic [15:0] m_mem [64];
    logic [63:0] m_valid = '0;

    function automatic logic [15:0] model_rd(input logic [23:0] a);
        if (m_valid[a[5:0]]) return m_mem[a[5:0]];
        if (a == 24'h000123) return 16'hBEEF;
        return a[15:0] ^ 16'h3C3C;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            mem_ack  <= 1'b0;
            mem_dout <= '0;
        end else if (!m_busy) begin
            if (mem_as) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_ad   <= mem_ad;
                m_nwr  <= mem_nwr;
                m_din  <= mem_din;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == c_lat && !stub_mute) begin
                mem_ack <= 1'b1;
                if (m_nwr) begin
                    mem_dout <= model_rd(m_ad);
                end else begin
                    m_mem[m_ad[5:0]]   <= m_din;
                    m_valid[m_ad[5:0]] <= 1'b1;
                end
            end else if (m_cnt == c_lat + c_ack_width) begin
                mem_ack <= 1'b0;
                m_busy  <= 1'b0;
            end
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          ack_cyc = 0;
    logic        prev_mack = 1'b0;
    logic [23:0] held_ad;
    logic        held_nwr;
    logic        stab_bad = 1'b0;
    logic        rr_win = 1'b0;
    int          b0_cnt = 0, b1_cnt = 0;
    int          as_log[$];
    exp_t        sb_q[$];
    logic [15:0] last_p0 = '0, last_p1 = '0;
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (mem_ack) begin
            if (!prev_mack) begin
                rise_cyc = cyc;
                held_ad  = mem_ad;
                held_nwr = mem_nwr;
            end else if (mem_ad !== held_ad || mem_nwr !== held_nwr) begin
                stab_bad = 1'b1;
            end
        end
        prev_mack = mem_ack;
        if (mem_as) as_log.push_back(cyc);
        if (rr_win) begin
            b0_cnt += int'(p0_ack_b);
            b1_cnt += int'(p1_ack_b);
        end
    endtask

    task automatic drive(input logic port, input logic nwr, input logic [23:0] ad,
                         input logic [15:0] din);
        if (port) begin
            p1_nwr = nwr; p1_ad = ad; p1_din = din; p1_req = 1'b1;
        end else begin
            p0_nwr = nwr; p0_ad = ad; p0_din = din; p0_req = 1'b1;
        end
    endtask

    task automatic push_exp(input logic port, input logic lat, input logic [15:0] d);
        exp_t e;
        e.port = port; e.chk_lat = lat; e.dout = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_as(output int c);
        int n = 0;
        c = -1;
        while (n < 100) begin
            tick();
            n++;
            if (mem_as) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_checks++; n_errors++;
            $display("FAIL wait_as: got no mem_as required one within 100 cycles");
        end
    endtask

    task automatic wait_ack(input string name, input bit drop);
        int   n = 0;
        exp_t e;
        while (!(p0_ack || p1_ack) && n < 80) begin
            tick();
            n++;
        end
        if (!(p0_ack || p1_ack)) begin
            n_checks++; n_errors++;
            $display("FAIL %s_ack: got no ack required one within 80 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        ack_cyc = cyc;
        if (drop) begin
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s_sb: got ack with empty scoreboard required none", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, "_port"}, {p1_ack, p0_ack}, e.port ? 2'b10 : 2'b01);
        chk({name, "_dout"}, e.port ? p1_dout : p0_dout, e.dout);
        if (e.port) last_p1 = e.dout; else last_p0 = e.dout;
        if (e.chk_lat) begin
            chk({name, "_lat"}, ack_cyc - rise_cyc, 1);
            chk({name, "_stable"}, stab_bad, 0);
        end
        stab_bad = 1'b0;
        tick();
        chk({name, "_pulse"}, p0_ack | p1_ack, 0);
    endtask

    initial begin
        int low_cnt;
        int as_c;
        int seen;
        logic [15:0] exp_d;

        vecs[0] = '{1'b0, 1'b1, 24'h000123, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 24'h3FFFFF, 16'h5A5A, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 24'h3FFFFF, 16'h0000, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b0, 24'h000042, 16'h1234, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 24'h000042, 16'h0000, 16'h1234};
        vecs[5] = '{1'b0, 1'b1, 24'h800007, 16'h0000, 16'h3C3B};
        vecs[6] = '{1'b1, 1'b1, 24'h000105, 16'h0000, 16'h3D39};

        rst_n = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0; p0_nwr = 1'b1; p1_nwr = 1'b1;
        p0_ad = '0; p1_ad = '0; p0_din = '0; p1_din = '0;
        repeat (3) tick();

        chk("rst_mem_rst", mem_rst, 1);
        chk("rst_mem_nwr", mem_nwr, 1);
        chk("rst_mem_as", mem_as, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_ad", mem_ad, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_douts", {p0_dout, p1_dout}, 0);
        chk("rst_twin", {mem_nwr_b, mem_rst_b, (mem_ad_b == 0 && mem_din_b == 0 &&
                          p0_dout_b == 0 && p1_dout_b == 0)}, 3'b111);

        // Init hold-off: request raised right at reset release.
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 24'h000123, 16'h0000);
        push_exp(1'b0, 1'b1, 16'hBEEF);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_as) break;
            if (!mem_rst) low_cnt++;
        end
        chk("init_as_seen", mem_as, 1);
        chk("init_low_min", (low_cnt >= c_init) ? 1 : 0, 1);
        chk("init_low_max", (low_cnt <= c_init + 2) ? 1 : 0, 1);
        tick();
        chk("init_as_pulse", mem_as, 0);
        wait_ack("init_read", 1'b1);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].port, vecs[i].nwr, vecs[i].ad, vecs[i].din);
            exp_d = vecs[i].nwr ? vecs[i].exp_dout : (vecs[i].port ? last_p1 : last_p0);
            push_exp(vecs[i].port, 1'b1, exp_d);
            wait_ack($sformatf("vec%0d", i), 1'b1);
            repeat (6) tick();
        end

        // Round-robin: the table ended on port 1, so port 0 goes first.
        as_log.delete();
        rr_win = 1'b1;
        drive(1'b0, 1'b1, 24'h000040, 16'h0000);
        drive(1'b1, 1'b1, 24'h000081, 16'h0000);
        for (int i = 0; i < 4; i++) push_exp(i[0], 1'b1, i[0] ? 16'h3CBD : 16'h3C7C);
        for (int i = 0; i < 4; i++) wait_ack($sformatf("rr%0d", i), i == 3);
        rr_win = 1'b0;
        chk("rr_as_count", as_log.size(), 4);
        for (int i = 1; i < as_log.size(); i++)
            chk($sformatf("rr_gap%0d", i), (as_log[i] - as_log[i-1] >= 19) ? 1 : 0, 1);
        chk("prio_p0_grants", b0_cnt, 4);
        chk("prio_p1_grants", b1_cnt, 0);
        repeat (6) tick();

        // Request dropped mid-flight: no ack may appear.
        drive(1'b0, 1'b1, 24'h000040, 16'h0000);
        wait_as(as_c);
        repeat (3) tick();
        p0_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (p0_ack || p1_ack) seen++;
        end
        chk("drop_no_ack", seen, 0);

        // Timeout against a controller that never acks.
        stub_mute = 1'b1;
        drive(1'b0, 1'b1, 24'h000050, 16'h0000);
        push_exp(1'b0, 1'b0, last_p0);
        wait_as(as_c);
        wait_ack("tmo", 1'b1);
        chk("tmo_cycle", ack_cyc - as_c, c_tmo + 2);
        chk("tmo_err", err, 1);
        chk("tmo_err_prio", err_b, 1);
        repeat (5) tick();
        chk("tmo_err_sticky", err, 1);
        stub_mute = 1'b0;
        repeat (20) tick();

        // Reset pulled eight cycles into a transaction.
        drive(1'b0, 1'b1, 24'h000123, 16'h0000);
        push_exp(1'b0, 1'b1, 16'hBEEF);
        wait_as(as_c);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rst", {mem_rst, mem_rst_b}, 2'b11);
        chk("mid_rst_outs", {mem_as, mem_nwr, err, p0_ack, p1_ack}, 5'b01000);
        sb_q.delete();
        last_p0 = '0;
        last_p1 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        push_exp(1'b0, 1'b1, 16'hBEEF);
        seen = 0;
        for (int i = 0; i < c_init; i++) begin
            tick();
            if (mem_as || p0_ack || p1_ack) seen++;
        end
        chk("mid_rst_init_holdoff", seen, 0);
        wait_ack("mid_rst_recover", 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
